mc_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the MIPS datapath (IFU, GPR, ALU, EXT, DM) one instruction at a time. It replaces the combinational single-cycle decoder.
- Drives every datapath control input.
- Adds PC-write and IR-write enables and a data-memory request/acknowledge handshake with timeout.
- Flags illegal opcodes and memory faults, and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 59 +++++
 rtl/mc_ctrl_decode.sv | 66 ++++++
 rtl/mc_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, instruction
// classes, opcode/funct values and datapath control codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IC_ALU     = 3'd0,
    IC_LOAD    = 3'd1,
    IC_STORE   = 3'd2,
    IC_BRANCH  = 3'd3,
    IC_JUMP    = 3'd4,
    IC_JAL     = 3'd5,
    IC_JR      = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] RS_ALU   = 2'b00;
  localparam logic [1:0] RS_DM    = 2'b01;
  localparam logic [1:0] RS_ONE   = 2'b10;
  localparam logic [1:0] RS_NPC   = 2'b11;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_R30   = 2'b10;
  localparam logic [1:0] RD_R31   = 2'b11;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class plus
// the per-instruction ALU, extender and operand-select controls.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [2:0] iclass_c,
  output logic [1:0] alu_ctl_c,
  output logic       ext_op_c,
  output logic       alu_src_c
);

  always_comb begin
    iclass_c  = IC_ILLEGAL;
    alu_ctl_c = ALU_ADD;
    ext_op_c  = 1'b0;
    alu_src_c = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: iclass_c = IC_ALU;
          FN_SUBU: begin
            iclass_c  = IC_ALU;
            alu_ctl_c = ALU_SUB;
          end
          FN_JR:   iclass_c = IC_JR;
          default: iclass_c = IC_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        iclass_c  = IC_ALU;
        alu_ctl_c = ALU_OR;
        alu_src_c = 1'b1;
      end
      OP_ADDI: begin
        iclass_c  = IC_ALU;
        alu_src_c = 1'b1;
        ext_op_c  = 1'b1;
      end
      OP_LUI: begin
        iclass_c  = IC_ALU;
        alu_ctl_c = ALU_LUI;
        alu_src_c = 1'b1;
      end
      OP_LW: begin
        iclass_c  = IC_LOAD;
        alu_src_c = 1'b1;
        ext_op_c  = 1'b1;
      end
      OP_SW: begin
        iclass_c  = IC_STORE;
        alu_src_c = 1'b1;
        ext_op_c  = 1'b1;
      end
      OP_BEQ: begin
        iclass_c  = IC_BRANCH;
        alu_ctl_c = ALU_SUB;
      end
      OP_J:    iclass_c = IC_JUMP;
      OP_JAL:  iclass_c = IC_JAL;
      default: iclass_c = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with data memory under a timeout, and counts retired instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             overflow,
  input  logic             mem_ack,
  output logic [1:0]       alu_ctl,
  output logic             ext_op,
  output logic [1:0]       reg_src,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic             npc_sel,
  output logic             j_ctl,
  output logic             jr_ctl,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_req,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [5:0]        fn_q, fn_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        fault_q, fault_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [2:0]        dec_class;
  iclass_e           icls;
  logic [1:0]        dec_alu_ctl;
  logic              dec_ext_op;
  logic              dec_alu_src;
  logic              retire;

  // In DECODE the classifier sees the live IR so legality is known before latching.
  always_comb begin
    op_d = op_q;
    fn_d = fn_q;
    if (state_q == ST_DECODE) begin
      op_d = opcode;
      fn_d = funct;
    end
  end

  mc_ctrl_decode u_decode (
    .op        (op_d),
    .fn        (fn_d),
    .iclass_c  (dec_class),
    .alu_ctl_c (dec_alu_ctl),
    .ext_op_c  (dec_ext_op),
    .alu_src_c (dec_alu_src)
  );

  assign icls = iclass_e'(dec_class);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    retire    = 1'b0;
    alu_ctl   = ALU_ADD;
    ext_op    = 1'b0;
    reg_src   = RS_ALU;
    reg_dst   = RD_RT;
    alu_src   = 1'b0;
    npc_sel   = 1'b0;
    j_ctl     = 1'b0;
    jr_ctl    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_req   = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        halted = 1'b1;
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_we   = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (icls == IC_ILLEGAL) begin
          state_d = ST_FAULT;
          fault_d = FLT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_ctl = dec_alu_ctl;
        ext_op  = dec_ext_op;
        alu_src = dec_alu_src;
        case (icls)
          IC_ALU:             state_d = ST_WB;
          IC_LOAD, IC_STORE:  state_d = ST_MEM;
          IC_BRANCH: begin
            npc_sel = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
          end
          IC_JUMP: begin
            j_ctl  = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          IC_JAL: begin
            j_ctl     = 1'b1;
            reg_dst   = RD_R31;
            reg_src   = RS_NPC;
            reg_write = 1'b1;
            pc_we     = 1'b1;
            retire    = 1'b1;
          end
          IC_JR: begin
            jr_ctl = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          default: begin
            state_d = ST_FAULT;
            fault_d = FLT_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        alu_ctl = dec_alu_ctl;
        ext_op  = dec_ext_op;
        alu_src = dec_alu_src;
        if (mem_ack) begin
          wait_d = '0;
          if (icls == IC_STORE) begin
            mem_write = 1'b1;
            pc_we     = 1'b1;
            retire    = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          wait_d  = '0;
          state_d = ST_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        if (icls == IC_LOAD) begin
          reg_src = RS_DM;
          reg_dst = RD_RT;
        end else begin
          // ALU result must stay stable while the GPR captures it.
          alu_ctl = dec_alu_ctl;
          ext_op  = dec_ext_op;
          alu_src = dec_alu_src;
          reg_dst = (op_q == OP_RTYPE) ? RD_RD : RD_RT;
          if (op_q == OP_ADDI && overflow) begin
            reg_src = RS_ONE;
            reg_dst = RD_R30;
          end
        end
      end
      ST_FAULT: halted = 1'b1;
      default:  state_d = ST_IDLE;
    endcase

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = run ? ST_FETCH : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      fault_q   <= FLT_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver queues expected commit/fault records,
// a negedge monitor pops and compares them when pc_we pulses or a fault appears.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, overflow, mem_ack;
  logic [5:0]  opcode, funct;
  logic [1:0]  alu_ctl, reg_src, reg_dst, fault;
  logic        ext_op, alu_src, npc_sel, j_ctl, jr_ctl, reg_write, mem_write;
  logic        pc_we, ir_we, mem_req, halted;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .overflow(overflow), .mem_ack(mem_ack), .alu_ctl(alu_ctl), .ext_op(ext_op),
    .reg_src(reg_src), .reg_dst(reg_dst), .alu_src(alu_src), .npc_sel(npc_sel),
    .j_ctl(j_ctl), .jr_ctl(jr_ctl), .reg_write(reg_write), .mem_write(mem_write),
    .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req), .halted(halted),
    .fault(fault), .retired(retired)
  );

  typedef struct {
    string       name;
    bit          is_fault;
    logic [1:0]  fault;
    int          lat;
    int          mreq;
    logic        rw, mw, npc, j, jr, asrc, ext;
    logic [1:0]  actl, rsrc, rdst;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(string name, int lat, int mreq, logic rw, logic mw,
                              logic npc, logic j, logic jr, logic [1:0] actl,
                              logic asrc, logic ext, logic [1:0] rsrc,
                              logic [1:0] rdst, logic [31:0] ret);
    exp_t e;
    e.name = name; e.is_fault = 1'b0; e.fault = 2'b00; e.lat = lat; e.mreq = mreq;
    e.rw = rw; e.mw = mw; e.npc = npc; e.j = j; e.jr = jr; e.actl = actl;
    e.asrc = asrc; e.ext = ext; e.rsrc = rsrc; e.rdst = rdst; e.ret = ret;
    return e;
  endfunction

  function automatic exp_t mkf(string name, logic [1:0] code, int lat, int mreq);
    exp_t e;
    e = mk(name, lat, mreq, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'd0);
    e.is_fault = 1'b1;
    e.fault    = code;
    return e;
  endfunction

  // Monitor: per-instruction cycle / mem_req / mem_write accounting, then scoreboard pops.
  int         cyc = 0, start_cyc = 0, mreq_cnt = 0, mwr_cnt = 0;
  logic [1:0] fault_prev = 2'b00;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mon_en) begin
      if (ir_we) begin
        start_cyc = cyc;
        mreq_cnt  = 0;
        mwr_cnt   = 0;
      end
      if (mem_req)   mreq_cnt++;
      if (mem_write) mwr_cnt++;
      check("rw_mw_exclusive", 64'(reg_write & mem_write), 64'(0));
      if (pc_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pc_we", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".kind"},      64'(e.is_fault), 64'(0));
          check({e.name, ".latency"},   64'(cyc - start_cyc + 1), 64'(e.lat));
          check({e.name, ".mem_req_n"}, 64'(mreq_cnt), 64'(e.mreq));
          check({e.name, ".reg_write"}, 64'(reg_write), 64'(e.rw));
          check({e.name, ".mem_write"}, 64'(mem_write), 64'(e.mw));
          check({e.name, ".npc_sel"},   64'(npc_sel), 64'(e.npc));
          check({e.name, ".j_ctl"},     64'(j_ctl), 64'(e.j));
          check({e.name, ".jr_ctl"},    64'(jr_ctl), 64'(e.jr));
          check({e.name, ".alu_ctl"},   64'(alu_ctl), 64'(e.actl));
          check({e.name, ".alu_src"},   64'(alu_src), 64'(e.asrc));
          check({e.name, ".ext_op"},    64'(ext_op), 64'(e.ext));
          check({e.name, ".reg_src"},   64'(reg_src), 64'(e.rsrc));
          check({e.name, ".reg_dst"},   64'(reg_dst), 64'(e.rdst));
          check({e.name, ".retired"},   64'(retired), 64'(e.ret));
        end
      end
      if (fault !== fault_prev && fault != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fault", 64'(fault), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".kind"},      64'(e.is_fault), 64'(1));
          check({e.name, ".fault"},     64'(fault), 64'(e.fault));
          check({e.name, ".latency"},   64'(cyc - start_cyc + 1), 64'(e.lat));
          check({e.name, ".mem_req_n"}, 64'(mreq_cnt), 64'(e.mreq));
          check({e.name, ".mem_wr_n"},  64'(mwr_cnt), 64'(0));
          check({e.name, ".halted"},    64'(halted), 64'(1));
          check({e.name, ".mem_req"},   64'(mem_req), 64'(0));
        end
      end
      fault_prev = fault;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(string name);
    int n = 0;
    while (ir_we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, ".fetch_seen"}, 64'(ir_we), 64'(1));
  endtask

  // Issue one instruction at its FETCH cycle; ack_after < 0 means never acknowledge.
  task automatic run_instr(exp_t e, logic [5:0] op, logic [5:0] fn, logic ovf,
                           int ack_after, logic run_after);
    int n = 0;
    int mcnt = 0;
    wait_fetch(e.name);
    opcode   = op;
    funct    = fn;
    overflow = ovf;
    run      = run_after;
    exp_q.push_back(e);
    do begin
      tick();
      n++;
      if (mem_req) begin
        mcnt++;
        mem_ack = (ack_after >= 0) && (mcnt == ack_after + 1);
      end else begin
        mem_ack = 1'b0;
      end
    end while (ir_we !== 1'b1 && halted !== 1'b1 && n < 60);
    mem_ack = 1'b0;
    check({e.name, ".completed"}, 64'(ir_we | halted), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; opcode = 6'd0; funct = 6'd0;
    overflow = 1'b0; mem_ack = 1'b0;
    do_reset();
    check("reset.halted",  64'(halted), 64'(1));
    check("reset.fault",   64'(fault), 64'(0));
    check("reset.retired", 64'(retired), 64'(0));
    check("reset.ir_we",   64'(ir_we), 64'(0));
    check("reset.pc_we",   64'(pc_we), 64'(0));
    check("reset.mem_req", 64'(mem_req), 64'(0));
    mon_en = 1'b1;

    run = 1'b1;
    //                name            lat mrq rw mw np j jr actl  as ex rsrc   rdst   ret
    run_instr(mk("addu",        4, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b01, 32'd0),
              6'b000000, 6'b100001, 0, -1, 1);
    run_instr(mk("addi_ovf",    4, 0, 1, 0, 0, 0, 0, 2'b00, 1, 1, 2'b10, 2'b10, 32'd1),
              6'b001000, 6'b000000, 1, -1, 1);
    run_instr(mk("addi",        4, 0, 1, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 32'd2),
              6'b001000, 6'b000101, 0, -1, 1);
    run_instr(mk("ori",         4, 0, 1, 0, 0, 0, 0, 2'b10, 1, 0, 2'b00, 2'b00, 32'd3),
              6'b001101, 6'b000000, 0, -1, 1);
    run_instr(mk("lui",         4, 0, 1, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00, 2'b00, 32'd4),
              6'b001111, 6'b000000, 0, -1, 1);
    run_instr(mk("subu",        4, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 2'b01, 32'd5),
              6'b000000, 6'b100011, 1, -1, 1);
    run_instr(mk("lw_wait3",    8, 4, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 2'b00, 32'd6),
              6'b100011, 6'b000000, 0, 3, 1);
    run_instr(mk("sw_ack0",     4, 1, 0, 1, 0, 0, 0, 2'b00, 1, 1, 2'b00, 2'b00, 32'd7),
              6'b101011, 6'b000000, 0, 0, 1);
    run_instr(mk("beq",         3, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 32'd8),
              6'b000100, 6'b000000, 0, -1, 1);
    run_instr(mk("jal",         3, 0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 2'b11, 2'b11, 32'd9),
              6'b000011, 6'b000000, 0, -1, 1);
    run_instr(mk("j",           3, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'd10),
              6'b000010, 6'b000000, 0, -1, 1);
    run_instr(mk("jr_stop",     3, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 32'd11),
              6'b000000, 6'b001000, 0, -1, 0);
    tick(); tick();
    check("stop.halted",  64'(halted), 64'(1));
    check("stop.ir_we",   64'(ir_we), 64'(0));
    check("stop.retired", 64'(retired), 64'(12));

    // Reset in the middle of a load's memory wait.
    run = 1'b1;
    wait_fetch("lw_abort");
    opcode = 6'b100011; funct = 6'd0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin tick(); n++; end
    check("lw_abort.mem_req_seen", 64'(mem_req), 64'(1));
    tick(); tick();
    rst = 1'b1; run = 1'b0;
    tick();
    check("mid_rst.halted",  64'(halted), 64'(1));
    check("mid_rst.mem_req", 64'(mem_req), 64'(0));
    check("mid_rst.retired", 64'(retired), 64'(0));
    check("mid_rst.fault",   64'(fault), 64'(0));
    check("mid_rst.pc_we",   64'(pc_we), 64'(0));
    rst = 1'b0;
    tick();

    run = 1'b1;
    run_instr(mkf("illegal_op", 2'b01, 3, 0), 6'b111111, 6'b000000, 0, -1, 1);
    tick(); tick(); tick();
    check("illegal.sticky",  64'(fault), 64'(1));
    check("illegal.halted",  64'(halted), 64'(1));
    check("illegal.ir_we",   64'(ir_we), 64'(0));
    check("illegal.retired", 64'(retired), 64'(0));
    do_reset();
    check("post_fault_rst.fault", 64'(fault), 64'(0));

    run = 1'b1;
    run_instr(mkf("illegal_funct", 2'b01, 3, 0), 6'b000000, 6'b000000, 0, -1, 1);
    do_reset();

    run = 1'b1;
    run_instr(mkf("sw_timeout", 2'b10, 20, 16), 6'b101011, 6'b000000, 0, -1, 1);
    tick(); tick();
    check("timeout.fault",   64'(fault), 64'(2));
    check("timeout.mem_req", 64'(mem_req), 64'(0));
    check("timeout.pc_we",   64'(pc_we), 64'(0));
    check("timeout.retired", 64'(retired), 64'(0));

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
